// File: rtl/clint_mh.sv
// clint_mh: multi-hart core-local interruptor.
// One shared 64-bit mtime advanced every TICK_DIV clocks, plus a mtimecmp and an
// msip register per hart. Registers are reached over a valid/ready MMIO request
// port with a registered one-cycle response. The timer and software interrupt
// lines for each hart are registered.
module clint_mh #(
  parameter int unsigned NUM_HARTS = 2,
  parameter logic [63:0] BASE_ADDR = 64'h200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_wen,
  input  logic [63:0]          i_req_addr,
  input  logic [63:0]          i_req_wdata,
  input  logic [7:0]           i_req_wstrb,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [63:0]          o_rsp_rdata,
  output logic                 o_rsp_err,
  output logic [NUM_HARTS-1:0] o_mtip,
  output logic [NUM_HARTS-1:0] o_msip
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0] MTIME_OFF = 16'hBFF8;

  // Architectural state
  logic [63:0]          mtime_q, mtime_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;

  // Response and interrupt output registers
  logic                 rsp_valid_q, rsp_valid_d;
  logic [63:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [NUM_HARTS-1:0] mtip_q, msip_out_q;

  // Decode results
  logic [63:0]          off;
  logic [15:0]          off16;
  logic                 in_win;
  logic                 hit_mtime;
  logic [NUM_HARTS-1:0] sel_msip;
  logic [NUM_HARTS-1:0] sel_cmp;
  logic                 dec_err;
  logic                 accept;
  logic                 wr_ok;
  logic                 tick;
  logic [63:0]          rd_mux;

  // Replace only the strobed bytes of a 64-bit register.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int k = 0; k < 8; k++) begin
      if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

  assign o_req_ready = !rsp_valid_q || i_rsp_ready;
  assign accept      = i_req_valid && o_req_ready;

  // Address decode: window check, per-register hits with alignment folded in.
  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    off       = i_req_addr - BASE_ADDR;
    off16     = off[15:0];
    in_win    = (off[63:16] == '0);
    hit_mtime = in_win && (off16 == MTIME_OFF);
    sel_msip  = '0;
    sel_cmp   = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      sel_msip[h] = in_win && (off16[15:2] == 14'(h)) && (off16[1:0] == 2'b00);
      sel_cmp[h]  = in_win && (off16[15:14] == 2'b01) && (off16[13:3] == 11'(h))
                    && (off16[2:0] == 3'b000);
    end
    dec_err = !(hit_mtime || (|sel_msip) || (|sel_cmp));
    wr_ok   = accept && i_req_wen && !dec_err;
  end

  // Read mux over pre-update register values, lane-aligned, zero elsewhere.
  always_comb begin
    rd_mux = '0;
    if (hit_mtime) rd_mux = mtime_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (sel_cmp[h]) rd_mux = mtimecmp_q[h];
      if (sel_msip[h]) begin
        if (off16[2]) rd_mux = {31'b0, msip_q[h], 32'b0};
        else          rd_mux = {63'b0, msip_q[h]};
      end
    end
  end

  // Next-state for timebase and per-hart registers; writes beat the increment.
  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_ok && hit_mtime) begin
      mtime_d = merge_bytes(mtime_q, i_req_wdata, i_req_wstrb);
      presc_d = '0;
    end
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (wr_ok && sel_cmp[h]) begin
        mtimecmp_d[h] = merge_bytes(mtimecmp_q[h], i_req_wdata, i_req_wstrb);
      end
      if (wr_ok && sel_msip[h]) begin
        if (off16[2]) begin
          if (i_req_wstrb[4]) msip_d[h] = i_req_wdata[32];
        end else begin
          if (i_req_wstrb[0]) msip_d[h] = i_req_wdata[0];
        end
      end
    end
  end

  // Response next-state: load on accept, drop valid on consume, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = dec_err;
      rsp_rdata_d = (i_req_wen || dec_err) ? 64'd0 : rd_mux;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State, response and interrupt registers.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q     <= '0;
      presc_q     <= '0;
      // NOTE: the compare array is reset element by element because its
      // all-ones value is what keeps timer interrupts quiet out of reset;
      // a storage array with no such meaning would be left unreset.
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
      msip_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mtip_q      <= '0;
      msip_out_q  <= '0;
    end else begin
      mtime_q     <= mtime_d;
      presc_q     <= presc_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      for (int h = 0; h < NUM_HARTS; h++) mtip_q[h] <= (mtime_q >= mtimecmp_q[h]);
      msip_out_q  <= msip_q;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_mtip      = mtip_q;
  assign o_msip      = msip_out_q;

endmodule

// File: tb/tb_clint_mh.sv
// tb_clint_mh: directed bench for clint_mh. Instance 0 runs TICK_DIV=1,
// instance 1 runs TICK_DIV=4. A vector table covers register access and
// decode errors; hand-written sequences cover timing-sensitive behaviour.
module tb_clint_mh;

  localparam logic [63:0] BASE = 64'h200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen   [2];
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [63:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [1:0]  mtip      [2];
  logic [1:0]  msip      [2];

  clint_mh #(.NUM_HARTS(2), .BASE_ADDR(BASE), .TICK_DIV(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_wen(req_wen[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]), .i_req_wstrb(req_wstrb[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]),
    .o_mtip(mtip[0]), .o_msip(msip[0])
  );

  clint_mh #(.NUM_HARTS(2), .BASE_ADDR(BASE), .TICK_DIV(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_wen(req_wen[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]), .i_req_wstrb(req_wstrb[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]),
    .o_mtip(mtip[1]), .o_msip(msip[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request on instance d; returns #1 after the acceptance edge,
  // when the response is visible (rsp_ready assumed high by the caller).
  task automatic do_req(input int d, input string name, input logic wen,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] strb,
                        output logic [63:0] rdata, output logic err);
    int n;
    n = 0;
    req_valid[d] = 1'b1;
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wstrb[d] = strb;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      total++;
      bad++;
      $display("FAIL %s: request not accepted within 20 cycles", name);
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    check({name, " rsp_valid"}, 64'(rsp_valid[d]), 64'd1);
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
  endtask

  task automatic xact(input int d, input string name, input logic wen,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] strb,
                      input logic [63:0] exp_rdata, input logic exp_err);
    logic [63:0] rd;
    logic        er;
    do_req(d, name, wen, addr, wdata, strb, rd, er);
    check({name, " rdata"}, rd, exp_rdata);
    check({name, " err"}, 64'(er), 64'(exp_err));
  endtask

  typedef struct {
    string       name;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic wen, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [7:0] strb,
                              input logic [63:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.strb = strb; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [63:0] v;
    logic [63:0] exp_b [9];

    // Register access and decode-error vectors, applied in order to instance 0.
    add("rd_msip1",      1'b0, BASE + 64'h4,     64'h0, 8'h00, 64'h1_0000_0000, 1'b0);
    add("rd_msip0",      1'b0, BASE + 64'h0,     64'h0, 8'h00, 64'h0,           1'b0);
    add("wr_msip0_set",  1'b1, BASE + 64'h0,     64'h1, 8'h01, 64'h0,           1'b0);
    add("rd_msip0_set",  1'b0, BASE + 64'h0,     64'h0, 8'h00, 64'h1,           1'b0);
    add("wr_msip0_clr",  1'b1, BASE + 64'h0,     64'h0, 8'h01, 64'h0,           1'b0);
    add("rd_msip0_clr",  1'b0, BASE + 64'h0,     64'h0, 8'h00, 64'h0,           1'b0);
    add("wr_cmp0_lo",    1'b1, BASE + 64'h4000,  64'h0, 8'h0F, 64'h0,           1'b0);
    add("rd_cmp0_lo",    1'b0, BASE + 64'h4000,  64'h0, 8'h00, 64'hFFFF_FFFF_0000_0000, 1'b0);
    add("wr_cmp0_all",   1'b1, BASE + 64'h4000,  ONES,  8'hFF, 64'h0,           1'b0);
    add("rd_cmp0_all",   1'b0, BASE + 64'h4000,  64'h0, 8'h00, ONES,            1'b0);
    add("rd_cmp1",       1'b0, BASE + 64'h4008,  64'h0, 8'h00, ONES,            1'b0);
    add("err_rd_4004",   1'b0, BASE + 64'h4004,  64'h0, 8'h00, 64'h0,           1'b1);
    add("err_wr_8000",   1'b1, BASE + 64'h8000,  ONES,  8'hFF, 64'h0,           1'b1);
    add("err_rd_10000",  1'b0, BASE + 64'h10000, 64'h0, 8'h00, 64'h0,           1'b1);
    add("err_wr_10000",  1'b1, BASE + 64'h10000, 64'h1, 8'hFF, 64'h0,           1'b1);
    add("rd_msip0_keep", 1'b0, BASE + 64'h0,     64'h0, 8'h00, 64'h0,           1'b0);
    add("err_wr_4004",   1'b1, BASE + 64'h4004,  64'h0, 8'hFF, 64'h0,           1'b1);
    add("rd_cmp0_keep",  1'b0, BASE + 64'h4000,  64'h0, 8'h00, ONES,            1'b0);
    add("err_rd_cmp2",   1'b0, BASE + 64'h4010,  64'h0, 8'h00, 64'h0,           1'b1);
    add("err_rd_msip2",  1'b0, BASE + 64'h8,     64'h0, 8'h00, 64'h0,           1'b1);
    add("err_rd_2",      1'b0, BASE + 64'h2,     64'h0, 8'h00, 64'h0,           1'b1);
    add("err_rd_bffc",   1'b0, BASE + 64'hBFFC,  64'h0, 8'h00, 64'h0,           1'b1);
    add("err_rd_below",  1'b0, BASE - 64'h8,     64'h0, 8'h00, 64'h0,           1'b1);
    add("rd_msip1_keep", 1'b0, BASE + 64'h4,     64'h0, 8'h00, 64'h1_0000_0000, 1'b0);

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_wstrb[d] = '0; rsp_ready[d] = 1'b1;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("rst rsp_rdata", rsp_rdata[0], 64'd0);
    check("rst rsp_err",   64'(rsp_err[0]), 64'd0);
    check("rst mtip",      64'(mtip[0]), 64'd0);
    check("rst msip",      64'(msip[0]), 64'd0);
    check("rst req_ready", 64'(req_ready[0]), 64'd1);
    rst_n = 1'b1;

    // Ten edges after release mtime is 10; the read accepted on the next edge
    // returns that pre-increment value.
    repeat (10) @(posedge clk);
    #1;
    check("idle mtip", 64'(mtip[0]), 64'd0);
    xact(0, "mtime_after_10", 1'b0, BASE + 64'hBFF8, 64'h0, 8'h00, 64'd10, 1'b0);

    // TICK_DIV=4: write 100, then one read per cycle. The write clears the
    // prescaler, so the value steps on the 4th and 8th edge after the write.
    exp_b = '{64'd100, 64'd100, 64'd100, 64'd100, 64'd101, 64'd101, 64'd101, 64'd101, 64'd102};
    xact(1, "div4_wr_mtime", 1'b1, BASE + 64'hBFF8, 64'd100, 8'hFF, 64'h0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      xact(1, $sformatf("div4_rd%0d", k + 1), 1'b0, BASE + 64'hBFF8, 64'h0, 8'h00, exp_b[k], 1'b0);
    end

    // msip[1]: wrong strobe does nothing, matching strobe sets it, o_msip lags one cycle.
    xact(0, "msip1_wr_s01", 1'b1, BASE + 64'h4, 64'h1_0000_0000, 8'h01, 64'h0, 1'b0);
    @(posedge clk); #1;
    check("msip_after_s01", 64'(msip[0]), 64'd0);
    xact(0, "msip1_wr_s10", 1'b1, BASE + 64'h4, 64'h1_0000_0000, 8'h10, 64'h0, 1'b0);
    check("msip_write_edge", 64'(msip[0]), 64'd0);
    @(posedge clk); #1;
    check("msip_next_cycle", 64'(msip[0]), 64'b10);

    // Timer: the read at edge R returns v, the write lands at R+1 where mtime is
    // v+1 before the edge and v+2 after it. mtimecmp = v+7 is "mtime+5" relative
    // to the post-write value, reached after edge W+5 and seen on o_mtip at W+6.
    do_req(0, "mtip_rd_mtime", 1'b0, BASE + 64'hBFF8, 64'h0, 8'h00, v, er);
    xact(0, "mtip_wr_cmp1", 1'b1, BASE + 64'h4008, v + 64'd7, 8'hFF, 64'h0, 1'b0);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      if (j == 5) check("mtip1_w+5", 64'(mtip[0][1]), 64'd0);
      if (j == 6) check("mtip1_w+6", 64'(mtip[0][1]), 64'd1);
    end
    check("mtip0_quiet", 64'(mtip[0][0]), 64'd0);
    xact(0, "mtip_wr_cmp1_ones", 1'b1, BASE + 64'h4008, ONES, 8'hFF, 64'h0, 1'b0);
    check("mtip1_write_edge", 64'(mtip[0][1]), 64'd1);
    @(posedge clk); #1;
    check("mtip1_fall", 64'(mtip[0][1]), 64'd0);

    // Table-driven register and error vectors.
    foreach (vecs[i]) begin
      xact(0, vecs[i].name, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Backpressure: first response held 3 cycles while a second request waits.
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = BASE + 64'h4;
    req_wdata[0] = '0;   req_wstrb[0] = '0;
    @(posedge clk); #1;
    req_addr[0] = BASE + 64'h4008;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_valid%0d", c), 64'(rsp_valid[0]), 64'd1);
      check($sformatf("bp_rdata%0d", c), rsp_rdata[0], 64'h1_0000_0000);
      check($sformatf("bp_err%0d", c),   64'(rsp_err[0]), 64'd0);
      check($sformatf("bp_ready%0d", c), 64'(req_ready[0]), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    #1;
    check("bp_ready_release", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("bp_second_valid", 64'(rsp_valid[0]), 64'd1);
    check("bp_second_rdata", rsp_rdata[0], ONES);
    @(posedge clk); #1;
    check("bp_drained", 64'(rsp_valid[0]), 64'd0);

    // Reset with a response pending.
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = BASE + 64'h4000;
    req_wdata[0] = 64'd5; req_wstrb[0] = 8'hFF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("rst_pending_valid", 64'(rsp_valid[0]), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(rsp_valid[0]), 64'd0);
    check("rst_mid_mtip",  64'(mtip[0]), 64'd0);
    check("rst_mid_msip",  64'(msip[0]), 64'd0);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    rst_n = 1'b1;
    xact(0, "post_rst_cmp0",  1'b0, BASE + 64'h4000, 64'h0, 8'h00, ONES, 1'b0);
    xact(0, "post_rst_msip1", 1'b0, BASE + 64'h4,    64'h0, 8'h00, 64'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clint_mh.md
Name: clint_mh

Overview:
- Multi-hart core-local interruptor: one shared 64-bit mtime, per-hart mtimecmp and msip.
- Drives a registered timer-interrupt line and a software-interrupt line per hart into the CSR units.
- Sits on the MEM-stage MMIO path behind a valid/ready request port, with a 1-cycle response carrying read data and an error flag.
- mtime advances once every TICK_DIV clocks.

Parameters:
- NUM_HARTS, 2: number of harts; sets count of mtimecmp/msip registers and interrupt lines (1..16).
- BASE_ADDR, 64'h200_0000: base of the 64 KiB CLINT window.
- TICK_DIV, 1: clocks per mtime increment (>=1); 1 means increment every clock.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when valid&&ready
- i_req_wen  in  1  1=write, 0=read
- i_req_addr  in  64  byte address
- i_req_wdata  in  64  write data, lane-aligned
- i_req_wstrb  in  8  byte write strobes
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed
- o_rsp_rdata  out  64  read data, lane-aligned; 0 on writes/errors
- o_rsp_err  out  1  unmapped or misaligned access
- o_mtip  out  NUM_HARTS  timer interrupt pending per hart
- o_msip  out  NUM_HARTS  software interrupt pending per hart

Behaviour:
- Reset (async assert, sync-deassert handled upstream) values:
  - mtime=0; prescaler=0.
  - every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt fires at reset.
  - msip=0; o_mtip=0; o_msip=0.
  - o_rsp_valid=0; o_rsp_rdata=0; o_rsp_err=0.
- Address map, offsets from BASE_ADDR:
  - msip[h] at 4*h, 32-bit, only bit0 implemented, upper bits read 0.
  - mtimecmp[h] at 0x4000+8*h, 64-bit.
  - mtime at 0xBFF8, 64-bit.
  - Any other offset, an address outside the window, or misalignment is an error. Misaligned means msip not 4-aligned, or a 64-bit register not 8-aligned.
- Lanes:
  - 64-bit registers use all 8 strobes; byte k of the register is written iff wstrb[k].
  - msip with addr[2]=0 uses byte 0 (wdata[0]); with addr[2]=1 it uses byte 4 (wdata[32]). Only the matching strobe bit enables the write.
  - Read data is placed in the same lane; other bits are 0.
- Handshake:
  - o_req_ready = !o_rsp_valid || i_rsp_ready.
  - An accepted request updates registers at that clock edge, and o_rsp_valid asserts the next cycle.
  - rdata/err hold stable while o_rsp_valid && !i_rsp_ready.
  - Back-to-back requests give 1 response per cycle when i_rsp_ready=1.
  - Errored writes modify nothing; errored reads return rdata=0.
  - Writes return rdata=0, err=0.
- Read values:
  - Read data is sampled from register values before the same-edge update: a read of mtime returns the pre-increment value.
  - A read of a register written in the previous response cycle returns the new value.
- Timebase:
  - The prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - On the wrap cycle, mtime <= mtime+1, wrapping from all-ones to 0 with no flag.
  - An accepted mtime write has priority over the increment on the same edge, applied per strobed byte; non-strobed bytes keep their pre-increment value.
  - An mtime write also clears the prescaler.
- Interrupts:
  - o_mtip[h] <= (mtime >= mtimecmp[h]), unsigned compare on current register values, registered. This gives 1 cycle of lag after any mtime/mtimecmp change.
  - o_msip[h] <= msip[h]; visible the cycle after the write edge.
  - o_mtip is level, not sticky: writing mtimecmp above mtime deasserts it 1 cycle after the write edge.
- Reset mid-operation: a pending response is dropped (o_rsp_valid=0); all registers return to reset values immediately.

Test Plan:
- TICK_DIV=1, release reset, idle 10 clocks -> read mtime returns 10 (±0 at fixed sample point), err=0; o_mtip=0 throughout.
- TICK_DIV=4 -> mtime increments exactly on every 4th clock. Write mtime=100 mid-period -> next increment to 101 occurs 4 clocks after the write edge.
- Write mtimecmp[1]=mtime+5 with wstrb=8'hFF -> o_mtip[1] rises exactly 6 clocks after the write edge, o_mtip[0] stays 0. Then write mtimecmp[1]=all-ones -> o_mtip[1] falls 1 clock after that write.
- Write msip[1] (offset 4, wdata[32]=1, wstrb=8'h10) -> o_msip=2'b10 next cycle. Same write with wstrb=8'h01 -> no change. Read offset 4 -> rdata=64'h1_0000_0000.
- Error cases -> err=1, rdata=0, no register changes:
  - read offset 0x4004 (misaligned);
  - write offset 0x8000;
  - access at BASE_ADDR+0x1_0000.
- Hold i_rsp_ready=0 for 3 cycles with a second request valid -> o_req_ready=0 and the first response stays stable. After i_rsp_ready=1, the second request is accepted and responds on the next cycle. Assert rst_n=0 while a response is pending -> o_rsp_valid=0 and mtimecmp reads all-ones after reset.
